// File: rtl/uart_rx_fifo_if.sv
// Receive-side handshake bundle: head-of-FIFO word with status flags, drained by valid/ready.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_break;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data, rx_parity_err, rx_frame_err, rx_break, rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_parity_err, rx_frame_err, rx_break, rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, parity/framing/break detection,
// and a first-word-fall-through FIFO holding received words with their status.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 200_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rxd,
    uart_rx_fifo_if.master                   rx,
    output logic                             rx_busy,
    output logic                             overrun,
    input  logic                             overrun_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
    localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;
    localparam int unsigned HALF       = BIT_CYCLES / 2;
    localparam int unsigned PW         = $clog2(BIT_CYCLES);
    localparam int unsigned NW         = $clog2(DATA_BITS + 1);
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned EW         = DATA_BITS + 3;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK_WAIT
    } state_t;

    state_t               state;
    logic                 rxd_m, rxd_s;
    logic [2:0]           sh;
    logic [PW-1:0]        phase;
    logic [NW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr, allz;
    logic                 wr_req;
    logic [EW-1:0]        wr_entry;

    logic bit_c, at_half_c, at_wrap_c, exp_par_c, stop_ferr_c, stop_brk_c;

    assign bit_c       = (sh[0] & sh[1]) | (sh[0] & sh[2]) | (sh[1] & sh[2]);
    assign at_half_c   = (phase == PW'(HALF));
    assign at_wrap_c   = (phase == PW'(BIT_CYCLES - 1));
    assign exp_par_c   = (^shreg) ^ (PARITY == 1);
    assign stop_ferr_c = ferr | ~bit_c;
    assign stop_brk_c  = allz & ~bit_c;

    // Synchronizer and vote window; reset to idle-high so release cannot look like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            sh    <= 3'b111;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            sh    <= {sh[1:0], rxd_s};
        end
    end

    // Frame FSM; the edge cycle counts as phase 0, so the counter restarts at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            allz     <= 1'b0;
            wr_req   <= 1'b0;
            wr_entry <= '0;
            rx_busy  <= 1'b0;
        end else begin
            wr_req <= 1'b0;
            if (state != S_IDLE)
                phase <= at_wrap_c ? '0 : phase + PW'(1);
            case (state)
                S_IDLE: begin
                    if (!rxd_s && sh[0]) begin
                        state   <= S_START;
                        phase   <= PW'(1);
                        bit_cnt <= '0;
                        perr    <= 1'b0;
                        ferr    <= 1'b0;
                        allz    <= 1'b1;
                        rx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (at_half_c && bit_c) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end else if (at_wrap_c) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_half_c) begin
                        shreg   <= {bit_c, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + NW'(1);
                        if (bit_c) allz <= 1'b0;
                    end
                    if (at_wrap_c && bit_cnt == NW'(DATA_BITS)) begin
                        bit_cnt <= '0;
                        state   <= (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (at_half_c) begin
                        if (bit_c != exp_par_c) perr <= 1'b1;
                        if (bit_c) allz <= 1'b0;
                    end
                    if (at_wrap_c) state <= S_STOP;
                end
                S_STOP: begin
                    if (at_half_c) begin
                        if (bit_cnt == NW'(STOP_BITS - 1)) begin
                            wr_req   <= 1'b1;
                            wr_entry <= {stop_brk_c, stop_ferr_c | stop_brk_c, perr, shreg};
                            state    <= stop_brk_c ? S_BRK_WAIT : S_IDLE;
                            rx_busy  <= stop_brk_c;
                        end else begin
                            bit_cnt <= bit_cnt + NW'(1);
                            ferr    <= stop_ferr_c;
                            allz    <= stop_brk_c;
                        end
                    end
                end
                S_BRK_WAIT: begin
                    if (rxd_s) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          valid_q;
    logic [EW-1:0] head_c;
    logic [CW-1:0] count_nxt_c;
    logic          full_c, pop_c, push_c;

    assign full_c = (fifo_count == CW'(FIFO_DEPTH));
    assign pop_c  = valid_q && rx.rx_ready;
    assign push_c = wr_req && (!full_c || pop_c);
    assign head_c = mem[rd_ptr];

    always_comb begin
        count_nxt_c = fifo_count;
        if (push_c && !pop_c)
            count_nxt_c = fifo_count + CW'(1);
        else if (!push_c && pop_c)
            count_nxt_c = fifo_count - CW'(1);
    end

    // FWFT storage; a pop in the same cycle frees the slot a full-FIFO push lands in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            valid_q    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= count_nxt_c;
            valid_q    <= (count_nxt_c != '0);
            if (wr_req && !push_c)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign rx.rx_data       = head_c[DATA_BITS-1:0];
    assign rx.rx_parity_err = head_c[DATA_BITS];
    assign rx.rx_frame_err  = head_c[DATA_BITS+1];
    assign rx.rx_break      = head_c[DATA_BITS+2];
    assign rx.rx_valid      = valid_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: three receiver configurations (8N1 depth 4, 8E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_fifo;
    localparam int unsigned BC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rxd_a, rxd_b, rxd_c;
    logic       clr_a, clr_b, clr_c;
    logic       busy_a, busy_b, busy_c;
    logic       ovr_a, ovr_b, ovr_c;
    logic [2:0] cnt_a;
    logic [4:0] cnt_b, cnt_c;

    uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_b ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_c ();

    uart_rx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .rx(if_a), .rx_busy(busy_a),
        .overrun(ovr_a), .overrun_clr(clr_a), .fifo_count(cnt_a));
    uart_rx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .rx(if_b), .rx_busy(busy_b),
        .overrun(ovr_b), .overrun_clr(clr_b), .fifo_count(cnt_b));
    uart_rx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_c (
        .clk(clk), .rst(rst), .rxd(rxd_c), .rx(if_c), .rx_busy(busy_c),
        .overrun(ovr_c), .overrun_clr(clr_c), .fifo_count(cnt_c));

    // Every accepted word, as {break, frame_err, parity_err, data}
    logic [10:0] q_a[$], q_b[$], q_c[$];
    always @(negedge clk) begin
        if (if_a.rx_valid && if_a.rx_ready) q_a.push_back({if_a.rx_break, if_a.rx_frame_err, if_a.rx_parity_err, if_a.rx_data});
        if (if_b.rx_valid && if_b.rx_ready) q_b.push_back({if_b.rx_break, if_b.rx_frame_err, if_b.rx_parity_err, if_b.rx_data});
        if (if_c.rx_valid && if_c.rx_ready) q_c.push_back({if_c.rx_break, if_c.rx_frame_err, if_c.rx_parity_err, if_c.rx_data});
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int w, input logic v);
        case (w)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic send(input int w, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(w, bits[i]);
            tick(BC);
        end
    endtask

    function automatic int qsize(input int w);
        case (w)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic pop_q(input int w, output logic [10:0] e);
        case (w)
            0:       e = q_a.pop_front();
            1:       e = q_b.pop_front();
            default: e = q_c.pop_front();
        endcase
    endtask

    task automatic wait_q(input int w, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (qsize(w) != 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (qsize(w) != 0) ok = 1'b1;
    endtask

    typedef struct {
        int          w;
        logic [31:0] bits;
        int          n;
        int          idle;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [10:0] e;
        bit          ok;
        bit          seen;
        int          lat;

        // line bits LSB first: start, data, [parity], stop(s)
        vt[0] = '{0, 32'({1'b1, 8'hA5, 1'b0}),       10, 0,  {3'b000, 8'hA5}, "n1_a5"};
        vt[1] = '{0, 32'({1'b1, 8'h3C, 1'b0}),       10, 32, {3'b000, 8'h3C}, "n1_3c"};
        vt[2] = '{1, 32'({1'b1, 1'b0, 8'h01, 1'b0}), 11, 32, {3'b001, 8'h01}, "e1_01_badpar"};
        vt[3] = '{1, 32'({1'b1, 1'b0, 8'h03, 1'b0}), 11, 32, {3'b000, 8'h03}, "e1_03_goodpar"};
        vt[4] = '{1, 32'({1'b1, 1'b1, 8'h80, 1'b0}), 11, 32, {3'b000, 8'h80}, "e1_80_goodpar"};
        vt[5] = '{2, 32'({1'b1, 1'b1, 8'h55, 1'b0}), 11, 32, {3'b000, 8'h55}, "n2_55"};
        vt[6] = '{2, 32'({1'b0, 1'b1, 8'h55, 1'b0}), 11, 32, {3'b010, 8'h55}, "n2_stop2_low"};

        rst = 1'b1;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        if_a.rx_ready = 1'b0; if_b.rx_ready = 1'b1; if_c.rx_ready = 1'b1;
        tick(3);
        chk("rst_valid", 32'(if_a.rx_valid), 0);
        chk("rst_data", 32'(if_a.rx_data), 0);
        chk("rst_flags", 32'({if_a.rx_break, if_a.rx_frame_err, if_a.rx_parity_err}), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_overrun", 32'(ovr_a), 0);
        chk("rst_count", 32'(cnt_a), 0);
        rst = 1'b0;
        if_a.rx_ready = 1'b1;
        tick(20);

        for (int i = 0; i < 7; i++) begin
            send(vt[i].w, vt[i].bits, vt[i].n);
            wait_q(vt[i].w, 64, ok);
            chk({vt[i].name, "_arrived"}, 32'(ok), 1);
            if (ok) begin
                pop_q(vt[i].w, e);
                chk(vt[i].name, 32'(e), 32'(vt[i].exp));
            end
            if (vt[i].idle > 0) begin
                set_line(vt[i].w, 1'b1);
                tick(vt[i].idle);
            end
        end
        chk("n1_overrun", 32'(ovr_a), 0);
        chk("n1_count", 32'(cnt_a), 0);

        // Break: two whole frames of low line
        send(2, 32'h0, 22);
        chk("brk_entries", 32'(q_c.size()), 1);
        if (q_c.size() != 0) begin
            pop_q(2, e);
            chk("brk_word", 32'(e), 32'({3'b110, 8'h00}));
        end
        chk("brk_busy_while_low", 32'(busy_c), 1);
        set_line(2, 1'b1);
        tick(32);
        chk("brk_busy_after_high", 32'(busy_c), 0);
        chk("brk_no_more", 32'(q_c.size()), 0);

        // Short low glitch is rejected as a false start
        seen = 1'b0;
        set_line(0, 1'b0);
        for (int k = 0; k < 6; k++) begin tick(1); seen |= busy_a; end
        set_line(0, 1'b1);
        for (int k = 0; k < 30; k++) begin tick(1); seen |= busy_a; end
        chk("glitch_busy_pulse", 32'(seen), 1);
        chk("glitch_busy_idle", 32'(busy_a), 0);
        chk("glitch_count", 32'(cnt_a), 0);
        chk("glitch_no_entry", 32'(q_a.size()), 0);

        // Overrun with a depth-4 FIFO and the consumer stalled; also first-word latency
        if_a.rx_ready = 1'b0;
        lat = -1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(0, 32'({1'b1, 8'(8'h10 + i), 1'b0}), 10);
            end
            begin
                for (int k = 0; k < 400; k++) begin
                    if (if_a.rx_valid) begin lat = k; break; end
                    tick(1);
                end
            end
        join
        chk("ovr_first_latency", 32'(lat), 156);
        chk("ovr_count", 32'(cnt_a), 4);
        chk("ovr_flag", 32'(ovr_a), 1);
        chk("ovr_head", 32'(if_a.rx_data), 32'h10);
        if_a.rx_ready = 1'b1;
        tick(10);
        if_a.rx_ready = 1'b0;
        chk("ovr_drained", 32'(q_a.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (q_a.size() != 0) begin
                pop_q(0, e);
                chk($sformatf("ovr_word%0d", i), 32'(e), 32'(8'h10 + i));
            end
        end
        chk("ovr_count_empty", 32'(cnt_a), 0);
        chk("ovr_sticky", 32'(ovr_a), 1);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        chk("ovr_cleared", 32'(ovr_a), 0);

        // Reset in the middle of data bit 3, then a clean frame
        if_a.rx_ready = 1'b1;
        send(0, 32'({8'h5A, 1'b0}), 4);
        set_line(0, 1'b1);
        tick(8);
        chk("mid_busy_before_rst", 32'(busy_a), 1);
        rst = 1'b1;
        tick(3);
        chk("mid_rst_busy", 32'(busy_a), 0);
        chk("mid_rst_count", 32'(cnt_a), 0);
        rst = 1'b0;
        tick(40);
        chk("post_rst_no_start", 32'(busy_a), 0);
        chk("post_rst_no_entry", 32'(q_a.size()), 0);
        send(0, 32'({1'b1, 8'h5A, 1'b0}), 10);
        tick(16);
        chk("post_rst_entries", 32'(q_a.size()), 1);
        if (q_a.size() != 0) begin
            pop_q(0, e);
            chk("post_rst_word", 32'(e), 32'({3'b000, 8'h5A}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end
endmodule
